// File: rtl/apb_uart_fifo_pkg.sv
// Shared definitions for the APB UART.
// Holds the register byte offsets, CTRL/STATUS/INTR bit positions,
// the minimum usable baud divisor and the TX/RX FSM state encodings.
package apb_uart_fifo_pkg;

    // Register byte offsets, as seen in paddr[4:0]
    localparam logic [4:0] OFF_CTRL       = 5'h00;
    localparam logic [4:0] OFF_BAUD       = 5'h04;
    localparam logic [4:0] OFF_TXDATA     = 5'h08;
    localparam logic [4:0] OFF_RXDATA     = 5'h0C;
    localparam logic [4:0] OFF_STATUS     = 5'h10;
    localparam logic [4:0] OFF_INTR_EN    = 5'h14;
    localparam logic [4:0] OFF_INTR_STATE = 5'h18;

    // CTRL bits
    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_LOOPBACK = 2;

    // STATUS bits
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_BUSY  = 4;
    localparam int ST_RX_BUSY  = 5;

    // INTR_STATE / INTR_EN bits
    localparam int INTR_TX_EMPTY  = 0;
    localparam int INTR_RX_VALID  = 1;
    localparam int INTR_OVERRUN   = 2;
    localparam int INTR_FRAME_ERR = 3;

    // Smaller divisors leave no room for a mid-bit sample point
    localparam int unsigned MIN_BAUD = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO used for both the TX and RX byte queues.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and data
//   pop, rdata      read request; rdata shows the head (first-word fall-through)
//   full, empty     occupancy flags
//   count           number of stored entries
// A push and pop in the same cycle both take effect even when full or empty,
// leaving count unchanged. When empty, the pushed word is forwarded to rdata.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // A full FIFO still accepts a push if the head leaves in the same cycle,
    // and an empty one still honours a pop if a word arrives with it.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & (~empty | push);

    assign rdata = empty ? wdata : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB3 slave UART, 8N1, with TX and RX FIFOs.
// Ports:
//   pclk_i, prst_ni                     clock, asynchronous active-low reset
//   psel_i, penable_i, pwrite_i,
//   paddr_i, pwdata_i                   APB request
//   prdata_o, pready_o, pslverr_o       APB response (zero wait state)
//   rx_i                                asynchronous serial input
//   tx_o                                serial output, idle high
//   intr_o                              registered level interrupt
module apb_uart_fifo #(
    parameter int unsigned      FIFO_DEPTH = 8,
    parameter int unsigned      DIV_W      = 16,
    parameter logic [DIV_W-1:0] RST_DIV    = 16'd868
) (
    input  logic        pclk_i,
    input  logic        prst_ni,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [11:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        intr_o
);

    import apb_uart_fifo_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- registers ----------------
    logic [2:0]       ctrl_q;
    logic [DIV_W-1:0] baud_q;
    logic [3:0]       intr_en_q;
    logic             overrun_q;
    logic             frame_err_q;
    logic             intr_q;

    // ---------------- APB decode ----------------
    logic       access;
    logic       addr_ok;
    logic [4:0] reg_off;
    logic       wr_ok;
    logic       rd_ok;
    logic       wr_ctrl, wr_baud, wr_intr_en, wr_intr_state;
    logic       tx_push, tx_drop;
    logic       rx_rd, rx_pop, rx_rd_err;
    logic       unused_bits;

    // ---------------- FIFOs ----------------
    logic [7:0]    tx_rdata, rx_rdata;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_pop;
    logic [CW-1:0] tx_count_unused, rx_count_unused;

    // ---------------- baud ----------------
    logic [DIV_W-1:0] baud_eff;
    logic [DIV_W-1:0] bit_len_m1;
    logic [DIV_W-1:0] half_m1;

    // ---------------- TX FSM ----------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_cnt_end;

    // ---------------- RX FSM ----------------
    rx_state_e        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic             rx_cnt_end;
    logic             rx_s1, rx_s2, rx_prev;
    logic             rx_in, rx_fall;
    logic             rx_push_req;
    logic             frame_err_set;
    logic             overrun_set;

    logic [5:0] status;
    logic [3:0] intr_state;

    // ================= APB =================
    assign access  = psel_i & penable_i;
    assign addr_ok = (paddr_i[11:5] == 7'd0) && (paddr_i[4:2] != 3'd7);
    assign reg_off = {paddr_i[4:2], 2'b00};
    assign wr_ok   = access & pwrite_i & addr_ok;
    assign rd_ok   = access & ~pwrite_i & addr_ok;

    assign wr_ctrl       = wr_ok & (reg_off == OFF_CTRL);
    assign wr_baud       = wr_ok & (reg_off == OFF_BAUD);
    assign wr_intr_en    = wr_ok & (reg_off == OFF_INTR_EN);
    assign wr_intr_state = wr_ok & (reg_off == OFF_INTR_STATE);

    // A full TX FIFO still takes the byte when the FSM pops in the same cycle
    assign tx_push   = wr_ok & (reg_off == OFF_TXDATA);
    assign tx_drop   = tx_push & tx_full & ~tx_pop;

    assign rx_rd     = rd_ok & (reg_off == OFF_RXDATA);
    assign rx_pop    = rx_rd & ~rx_empty;
    assign rx_rd_err = rx_rd & rx_empty;

    assign pready_o  = access;
    assign pslverr_o = access & (~addr_ok | tx_drop | rx_rd_err);

    // Address bits [1:0] and upper write-data bits carry no meaning
    assign unused_bits = ^{paddr_i[1:0], pwdata_i};

    assign status[ST_TX_FULL]  = tx_full;
    assign status[ST_TX_EMPTY] = tx_empty;
    assign status[ST_RX_FULL]  = rx_full;
    assign status[ST_RX_EMPTY] = rx_empty;
    assign status[ST_TX_BUSY]  = (tx_state_q != TX_IDLE);
    assign status[ST_RX_BUSY]  = (rx_state_q != RX_IDLE);

    assign intr_state[INTR_TX_EMPTY]  = tx_empty;
    assign intr_state[INTR_RX_VALID]  = ~rx_empty;
    assign intr_state[INTR_OVERRUN]   = overrun_q;
    assign intr_state[INTR_FRAME_ERR] = frame_err_q;

    always_comb begin
        prdata_o = '0;
        if (access && addr_ok) begin
            case (reg_off)
                OFF_CTRL:       prdata_o = {29'd0, ctrl_q};
                OFF_BAUD:       prdata_o = 32'(baud_q);
                OFF_RXDATA:     prdata_o = rx_empty ? 32'd0 : {24'd0, rx_rdata};
                OFF_STATUS:     prdata_o = {26'd0, status};
                OFF_INTR_EN:    prdata_o = {28'd0, intr_en_q};
                OFF_INTR_STATE: prdata_o = {28'd0, intr_state};
                default:        prdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            ctrl_q      <= '0;
            baud_q      <= RST_DIV;
            intr_en_q   <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            if (wr_ctrl)    ctrl_q    <= pwdata_i[2:0];
            if (wr_baud)    baud_q    <= pwdata_i[DIV_W-1:0];
            if (wr_intr_en) intr_en_q <= pwdata_i[3:0];
            // Hardware set takes priority over a W1C in the same cycle
            overrun_q   <= overrun_set |
                           (overrun_q & ~(wr_intr_state & pwdata_i[INTR_OVERRUN]));
            frame_err_q <= frame_err_set |
                           (frame_err_q & ~(wr_intr_state & pwdata_i[INTR_FRAME_ERR]));
            intr_q      <= |(intr_state & intr_en_q);
        end
    end

    assign intr_o = intr_q;

    // ================= FIFOs =================
    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (pclk_i),
        .rst_n (prst_ni),
        .push  (tx_push),
        .wdata (pwdata_i[7:0]),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count_unused)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (pclk_i),
        .rst_n (prst_ni),
        .push  (rx_push_req),
        .wdata (rx_shift_d),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count_unused)
    );

    // ================= baud timing =================
    // Bit counters are reloaded at each bit boundary, so a divisor change
    // only affects the bit that starts after it.
    assign baud_eff   = (baud_q < DIV_W'(MIN_BAUD)) ? DIV_W'(MIN_BAUD) : baud_q;
    assign bit_len_m1 = baud_eff - DIV_W'(1);
    assign half_m1    = (baud_eff >> 1) - DIV_W'(1);

    // ================= TX =================
    assign tx_cnt_end = (tx_cnt_q == '0);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_rdata;
                    tx_cnt_d   = bit_len_m1;
                    tx_line_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_end) begin
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_idx_d   = 3'd0;
                    tx_cnt_d   = bit_len_m1;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - DIV_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_end) begin
                    tx_cnt_d = bit_len_m1;
                    if (tx_idx_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_idx_d   = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - DIV_W'(1);
                end
            end
            TX_STOP: begin
                // tx_en is only consulted in IDLE, so clearing it mid-frame
                // lets the current frame complete.
                if (tx_cnt_end) begin
                    tx_line_d  = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - DIV_W'(1);
                end
            end
            default: begin
                tx_line_d  = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Line flop resets high asynchronously so a reset mid-frame idles tx_o at once
    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_idx_q   <= tx_idx_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign tx_o = tx_line_q;

    // ================= RX =================
    // Loopback takes the TX line directly; it is already in this clock domain.
    assign rx_in      = ctrl_q[CTRL_LOOPBACK] ? tx_line_q : rx_s2;
    assign rx_fall    = rx_prev & ~rx_in;
    assign rx_cnt_end = (rx_cnt_q == '0);

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_shift_d    = rx_shift_q;
        rx_idx_d      = rx_idx_q;
        rx_push_req   = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                // The edge cycle counts as the first clock of the start bit,
                // so half_m1 more clocks lands the sample mid-bit.
                if (ctrl_q[CTRL_RX_EN] && rx_fall) begin
                    rx_cnt_d   = half_m1;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_end) begin
                    if (rx_in) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_idx_d   = 3'd0;
                        rx_cnt_d   = bit_len_m1;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - DIV_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_end) begin
                    rx_shift_d = {rx_in, rx_shift_q[7:1]};
                    rx_cnt_d   = bit_len_m1;
                    if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_idx_d   = rx_idx_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - DIV_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_end) begin
                    rx_state_d = RX_IDLE;
                    if (rx_in) rx_push_req   = 1'b1;
                    else       frame_err_set = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - DIV_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // FIFO drops the byte itself when full and not popped; flag that case
    assign overrun_set = rx_push_req & rx_full & ~rx_pop;

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_idx_q   <= '0;
        end else begin
            rx_s1      <= rx_i;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_in;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_idx_q   <= rx_idx_d;
        end
    end

endmodule
